// File: rtl/ds_mbit_dac.sv
// Multi-bit delta-sigma modulator with 1st/2nd order selectable at run time. Saturating integrators set a sticky overload flag.
// A sample affects dout one cke after it is latched. There is no backpressure: state advances on every cke pulse.
module ds_mbit_dac #(
    parameter int DW    = 16,
    parameter int OBITS = 2,
    parameter int IW    = DW + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cke,
    input  logic             order2,
    input  logic [DW-1:0]    din,
    output logic [OBITS-1:0] dout,
    output logic             ovl,
    input  logic             ovl_clr
);

    localparam int L  = 1 << OBITS;
    localparam int SW = IW + 2;

    localparam logic signed [SW-1:0] SUM_MAX = SW'((longint'(1) << (IW - 1)) - 1);
    localparam logic signed [SW-1:0] SUM_MIN = ~SUM_MAX;
    localparam logic signed [IW-1:0] INT_MAX = SUM_MAX[IW-1:0];
    localparam logic signed [IW-1:0] INT_MIN = ~INT_MAX;

    // Output level k, spread evenly across the full input range.
    function automatic logic signed [IW-1:0] lvl(input int k);
        longint span;
        longint val;
        span = (longint'(1) << DW) - 1;
        val  = -(longint'(1) << (DW - 1)) + (longint'(k) * span) / longint'(L - 1);
        return IW'(val);
    endfunction

    // Decision threshold between levels k-1 and k, rounded towards minus infinity.
    function automatic logic signed [IW-1:0] thr(input int k);
        return IW'((longint'(lvl(k - 1)) + longint'(lvl(k))) >>> 1);
    endfunction

    logic signed [DW-1:0] din_reg;
    logic signed [IW-1:0] s1;
    logic signed [IW-1:0] s2;
    logic                 ord_q;

    logic signed [IW-1:0] q;
    logic signed [IW-1:0] v;
    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] sum2;
    logic signed [IW-1:0] s1n;
    logic signed [IW-1:0] s2n;
    logic                 c1;
    logic                 c2;
    logic                 mode_sw;
    logic                 clamp;

    always_comb begin
        q    = ord_q ? s2 : s1;
        dout = '0;
        for (int k = 1; k < L; k++) begin
            if (thr(k) < q) begin
                dout = dout + OBITS'(1);
            end
        end
    end

    always_comb begin
        v = lvl(0);
        for (int k = 1; k < L; k++) begin
            if (dout == OBITS'(k)) begin
                v = lvl(k);
            end
        end
    end

    // Sums carry two guard bits so the clamp sees the true overshoot.
    always_comb begin
        sum1 = {{2{s1[IW-1]}}, s1} + {{(SW-DW){din_reg[DW-1]}}, din_reg} - {{2{v[IW-1]}}, v};
        c1   = (sum1 > SUM_MAX) || (sum1 < SUM_MIN);
        if (sum1 > SUM_MAX) begin
            s1n = INT_MAX;
        end else if (sum1 < SUM_MIN) begin
            s1n = INT_MIN;
        end else begin
            s1n = sum1[IW-1:0];
        end

        // Second stage integrates the freshly updated first stage.
        sum2 = {{2{s2[IW-1]}}, s2} + {{2{s1n[IW-1]}}, s1n} - {{2{v[IW-1]}}, v};
        c2   = (sum2 > SUM_MAX) || (sum2 < SUM_MIN);
        if (sum2 > SUM_MAX) begin
            s2n = INT_MAX;
        end else if (sum2 < SUM_MIN) begin
            s2n = INT_MIN;
        end else begin
            s2n = sum2[IW-1:0];
        end

        mode_sw = (order2 != ord_q);
        clamp   = !mode_sw && (c1 || (ord_q && c2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_reg <= '0;
            s1      <= '0;
            s2      <= '0;
            ord_q   <= 1'b0;
            ovl     <= 1'b0;
        end else begin
            if (cke) begin
                din_reg <= din;
                if (mode_sw) begin
                    ord_q <= order2;
                    s1    <= '0;
                    s2    <= '0;
                end else begin
                    s1 <= s1n;
                    s2 <= ord_q ? s2n : '0;
                end
            end
            if (cke && clamp) begin
                ovl <= 1'b1;
            end else if (ovl_clr) begin
                ovl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ds_mbit_dac.sv
// Randomised and directed bench for ds_mbit_dac; two instances (wide and narrow integrators) against an arithmetic model.
module tb_ds_mbit_dac;

    localparam int DW = 16;
    localparam int L  = 4;

    logic        clk;
    logic        rst_n;
    logic        cke;
    logic        order2;
    logic [15:0] din;
    logic        ovl_clr;
    logic [1:0]  dout0;
    logic [1:0]  dout1;
    logic        ovl0;
    logic        ovl1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    longint ms1[2];
    longint ms2[2];
    longint mdreg;
    bit     mord[2];
    bit     movl[2];
    int     miw[2] = '{20, 18};

    ds_mbit_dac #(.DW(16), .OBITS(2), .IW(20)) u0 (
        .clk(clk), .rst_n(rst_n), .cke(cke), .order2(order2), .din(din),
        .dout(dout0), .ovl(ovl0), .ovl_clr(ovl_clr));

    ds_mbit_dac #(.DW(16), .OBITS(2), .IW(18)) u1 (
        .clk(clk), .rst_n(rst_n), .cke(cke), .order2(order2), .din(din),
        .dout(dout1), .ovl(ovl1), .ovl_clr(ovl_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic longint lv(input int k);
        return -(longint'(1) << (DW - 1)) + (longint'(k) * ((longint'(1) << DW) - 1)) / (L - 1);
    endfunction

    function automatic int mcode(input longint q);
        int n = 0;
        for (int k = 1; k < L; k++) begin
            real t;
            t = $floor(real'(lv(k - 1) + lv(k)) / 2.0);
            if (t < real'(q)) n++;
        end
        return n;
    endfunction

    function automatic longint mq(input int i);
        return mord[i] ? ms2[i] : ms1[i];
    endfunction

    function automatic longint sat(input longint x, input int w, output bit c);
        longint lo;
        longint hi;
        lo = -(longint'(1) << (w - 1));
        hi = -lo - 1;
        c  = (x > hi) || (x < lo);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic mreset();
        mdreg = 0;
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 0; ms2[i] = 0; mord[i] = 0; movl[i] = 0;
        end
    endtask

    task automatic mstep(input bit c, input bit o2, input logic [15:0] d, input bit clr);
        for (int i = 0; i < 2; i++) begin
            bit cl = 0;
            bit ca = 0;
            bit cb = 0;
            if (c) begin
                if (o2 != mord[i]) begin
                    mord[i] = o2;
                    ms1[i]  = 0;
                    ms2[i]  = 0;
                end else begin
                    longint v;
                    v      = lv(mcode(mq(i)));
                    ms1[i] = sat(ms1[i] + mdreg - v, miw[i], ca);
                    if (mord[i]) ms2[i] = sat(ms2[i] + ms1[i] - v, miw[i], cb);
                    else ms2[i] = 0;
                    cl = ca | cb;
                end
            end
            if (cl) movl[i] = 1;
            else if (clr) movl[i] = 0;
        end
        if (c) mdreg = longint'($signed(d));
    endtask

    task automatic step(input bit c, input bit o2, input logic [15:0] d, input bit clr);
        cke = c; order2 = o2; din = d; ovl_clr = clr;
        @(posedge clk);
        mstep(c, o2, d, clr);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout_iw20", dout0, mcode(mq(0)));
            check("ovl_iw20", ovl0, movl[0]);
            check("dout_iw18", dout1, mcode(mq(1)));
            check("ovl_iw18", ovl1, movl[1]);
        end
    end

    initial begin
        int     exp2[4] = '{1, 2, 1, 2};
        longint sum;
        int     held;
        int     n;
        bit     o2;

        rst_n = 1'b0; cke = 1'b0; order2 = 1'b0; din = '0; ovl_clr = 1'b0;
        mreset();
        #12;
        check("reset_dout", dout0, 2);
        check("reset_ovl", ovl0, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1;

        // Idle input toggles between the two middle codes.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0000, 0);
            check("zero_alt", dout0, exp2[i]);
        end

        // Positive full scale pins the top code, negative full scale the bottom code.
        for (int i = 0; i < 3; i++) step(1, 0, 16'h7fff, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 16'h7fff, 0);
        check("fs_pos_code", dout0, 3);
        for (int i = 0; i < 20; i++) step(1, 0, 16'h8000, 0);
        check("fs_neg_code", dout0, 0);
        check("fs_ovl", ovl0, 0);

        // Average output level tracks a DC input in both loop orders.
        for (int ord = 0; ord < 2; ord++) begin
            step(1, ord[0], 16'd8192, 0);
            sum = 0;
            for (int i = 0; i < 4096; i++) begin
                step(1, ord[0], 16'd8192, 0);
                sum += lv(dout0);
            end
            checks++;
            if (sum - 8192 * 4096 > 64 * 4096 || sum - 8192 * 4096 < -64 * 4096) begin
                errors++;
                $display("FAIL mean_order%0d actual=%0d expected=8192+-64", ord, sum / 4096);
            end
        end

        // Mode switch clears the loop; cke low freezes everything.
        for (int i = 0; i < 7; i++) step(1, 1, 16'd3000, 0);
        step(1, 0, 16'd3000, 0);
        check("modesw_dout0", dout0, 2);
        check("modesw_dout1", dout1, 2);
        step(1, 0, 16'd20000, 0);
        step(1, 0, 16'd20000, 0);
        held = mcode(mq(0));
        for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 1), 16'($urandom), 0);
        check("hold_dout", dout0, held);

        // Full-scale 2nd-order input overloads the narrow integrator.
        n = 0;
        while (!ovl1 && n < 3000) begin
            step(1, 1, 16'h7fff, 0);
            n++;
        end
        check("ovl_sets", ovl1, 1);
        step(1, 0, 16'h0000, 0);
        step(1, 0, 16'h0000, 0);
        step(0, 0, 16'h0000, 1);
        check("ovl_clr", ovl1, 0);
        n = 0;
        while (!ovl1 && n < 3000) begin
            step(1, 1, 16'h7fff, 0);
            n++;
        end
        for (int i = 0; i < 20; i++) step(1, 1, 16'h7fff, 0);
        step(1, 1, 16'h7fff, 1);
        check("ovl_set_wins", ovl1, 1);

        // Random stream with sparse cke, mode flips and clears.
        o2 = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d = {{3{d[15]}}, d[15:3]};
            if ($urandom_range(0, 63) == 0) o2 = ~o2;
            step($urandom_range(0, 3) != 0, o2, d, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        for (int i = 0; i < 300; i++) step(1, 1, 16'h7fff, 0);
        #2;
        rst_n = 1'b0;
        mreset();
        #1;
        check("async_rst_dout0", dout0, 2);
        check("async_rst_ovl0", ovl0, 0);
        check("async_rst_dout1", dout1, 2);
        check("async_rst_ovl1", ovl1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) step(1, 0, 16'($urandom), 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
